// File: rtl/arb_req_gen.sv
// arb_req_gen: two-channel burst request generator with grant protocol checking
module arb_req_gen #(
  parameter int LEN_W = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         push_valid,
  input  logic [2*LEN_W-1:0] push_len,
  output logic [1:0]         push_ready,
  output logic [1:0]         request,
  input  logic [1:0]         grant,
  output logic [1:0]         beat_valid,
  output logic [1:0]         beat_last,
  input  logic               err_clr,
  output logic [2:0]         err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;
  logic [1:0] perr;
  genvar c;
  for (c = 0; c < 2; c++) begin : g_ch
    state_t state, state_n;
    logic [LEN_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic ne, push, pop;
    logic [LEN_W-1:0] cnt;
    assign push = push_valid[c] & push_ready[c];
    assign pop = (state == REQ) & grant[c];
    assign push_ready[c] = occ != (AW+1)'(FIFO_DEPTH);
    assign request[c] = (state == REQ) || (state == XFER);
    assign beat_valid[c] = state == XFER;
    assign beat_last[c] = (state == XFER) && (cnt == '0);
    assign perr[c] = grant[c] ? (state == IDLE || state == GAP) : (state == XFER);
    always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_len[c*LEN_W +: LEN_W];
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ <= '0;
        ne <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        ne <= occ != '0;
      end
    end
    always_ff @(posedge clk) begin
      state <= reset ? IDLE : state_n;
      cnt <= reset ? '0 : pop ? mem[rd_ptr] :
             (state == XFER && grant[c] && cnt != '0) ? cnt - 1'b1 : cnt;
    end
    always_comb begin
      state_n = state;
      state_n = state == IDLE ? (ne ? REQ : IDLE) :
                state == REQ  ? (grant[c] ? XFER : REQ) :
                state == XFER ? ((!grant[c] || cnt == '0) ? GAP : XFER) : IDLE;
    end
  end
  always_ff @(posedge clk)
    err <= (reset || err_clr) ? 3'b000 : err | {&grant, perr};
endmodule
